// File: rtl/vc_arbiter.sv
// Weighted round-robin scheduler between two VC FIFOs with a registered routing stage
// that steers each popped word to destination D0 or D1 by word bit 4.
module vc_arbiter #(
  parameter int unsigned DATA_W  = 6,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned WEIGHT0 = 4,
  parameter int unsigned WEIGHT1 = 2
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              ENABLE,
  input  logic              VC0_EMPTY,
  input  logic              VC1_EMPTY,
  input  logic              VC0_VALID,
  input  logic              VC1_VALID,
  input  logic [DATA_W-1:0] DATA_OUT_VC0,
  input  logic [DATA_W-1:0] DATA_OUT_VC1,
  input  logic              D0_PAUSE,
  input  logic              D1_PAUSE,
  output logic              POP_VC0,
  output logic              POP_VC1,
  output logic              PUSH_D0,
  output logic              PUSH_D1,
  output logic [DATA_W-1:0] DATA_TO_D0,
  output logic [DATA_W-1:0] DATA_TO_D1,
  output logic [1:0]        ARB_STATE,
  output logic              ARB_ERR
);

  localparam int unsigned DestBit = 4;
  localparam logic [CNT_W-1:0] Last0 = CNT_W'(WEIGHT0 - 1);
  localparam logic [CNT_W-1:0] Last1 = CNT_W'(WEIGHT1 - 1);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StServeVc0 = 2'b01,
    StServeVc1 = 2'b10
  } arb_state_e;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pop0_q, pop1_q;
  logic              push0_q, push0_d, push1_q, push1_d;
  logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
  logic              err_q, err_d;

  logic              stall, elig0, elig1, pop0, pop1;
  logic              have_word;
  logic [DATA_W-1:0] word;

  assign stall = ~ENABLE | D0_PAUSE | D1_PAUSE;
  assign elig0 = ~VC0_EMPTY & ~stall;
  assign elig1 = ~VC1_EMPTY & ~stall;
  assign pop0  = (state_q == StServeVc0) & elig0;
  assign pop1  = (state_q == StServeVc1) & elig1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (elig0) begin
          state_d = StServeVc0;
        end else if (elig1) begin
          state_d = StServeVc1;
        end
      end
      StServeVc0: begin
        if (pop0) begin
          if (cnt_q == Last0) begin
            cnt_d = '0;
            if (elig1) state_d = StServeVc1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!stall) begin
          // Not stalled and no pop: VC0 has run dry, hand over or go idle.
          cnt_d   = '0;
          state_d = elig1 ? StServeVc1 : StIdle;
        end
      end
      StServeVc1: begin
        if (pop1) begin
          if (cnt_q == Last1) begin
            cnt_d = '0;
            if (elig0) state_d = StServeVc0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!stall) begin
          cnt_d   = '0;
          state_d = elig0 ? StServeVc0 : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // VC0 wins a simultaneous-valid collision; the VC1 word is dropped and flagged.
  always_comb begin
    have_word = VC0_VALID | VC1_VALID;
    word      = VC0_VALID ? DATA_OUT_VC0 : DATA_OUT_VC1;
    push0_d   = have_word & ~word[DestBit];
    push1_d   = have_word & word[DestBit];
    data0_d   = push0_d ? word : data0_q;
    data1_d   = push1_d ? word : data1_q;
    err_d     = err_q | (VC0_VALID & VC1_VALID) | (VC0_VALID & ~pop0_q)
              | (VC1_VALID & ~pop1_q);
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pop0_q  <= 1'b0;
      pop1_q  <= 1'b0;
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pop0_q  <= pop0;
      pop1_q  <= pop1;
      push0_q <= push0_d;
      push1_q <= push1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      err_q   <= err_d;
    end
  end

  assign POP_VC0    = pop0;
  assign POP_VC1    = pop1;
  assign PUSH_D0    = push0_q;
  assign PUSH_D1    = push1_q;
  assign DATA_TO_D0 = data0_q;
  assign DATA_TO_D1 = data1_q;
  assign ARB_STATE  = state_q;
  assign ARB_ERR    = err_q;

endmodule
